// File: rtl/bin2bcd_seq.sv
// Binary to packed-BCD converter: sequential double-dabble datapath, one shift per clock.
// Latency: a word accepted at edge N gives out_valid after edge N+BIN_W; one word per BIN_W+2 cycles.
// Backpressure: the result is held while out_ready=0, and in_ready stays low from accept until the result is taken.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_bin is sampled on the accept edge
//   in_bin[BIN_W]         unsigned word, or two's complement when SIGNED=1
//   out_valid/out_ready   output handshake; all out_* stay stable while out_valid=1
//   out_bcd[4*DIGITS]     packed BCD magnitude (mod 10^DIGITS), ones digit in [3:0]
//   out_neg               input was negative (SIGNED=1 only)
//   out_ovf               magnitude did not fit in DIGITS digits
//   out_lz[DIGITS]        bit i (i>=1) set when digit i and all higher digits are zero
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic [DIGITS-1:0]     out_lz
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   dig_q;
  logic [BIN_W-1:0]   mag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               ovf_q;

  logic               accept;
  logic               last_shift;
  logic               in_is_neg;
  logic [BIN_W-1:0]   mag_in;
  logic [BCD_W-1:0]   dig_adj;
  logic [BCD_W-1:0]   dig_shift;
  logic [BIN_W-1:0]   mag_shift;
  logic               ovf_bit;
  logic [DIGITS-1:0]  lz_next;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  // Negation stays BIN_W bits wide, so the most negative value maps to 2^(BIN_W-1).
  assign in_is_neg = (SIGNED != 0) && in_bin[BIN_W-1];
  assign mag_in    = in_is_neg ? (~in_bin + 1'b1) : in_bin;

  // Add-3 on every digit >= 5; 4-bit result, no inter-digit carry.
  always_comb begin
    dig_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5)
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      else
        dig_adj[4*i +: 4] = dig_q[4*i +: 4];
    end
  end

  // Shift {digits, magnitude} left; the bit falling off the top digit means the
  // value needs more digits than we have.
  assign ovf_bit   = dig_adj[BCD_W-1];
  assign dig_shift = {dig_adj[BCD_W-2:0], mag_q[BIN_W-1]};
  assign mag_shift = {mag_q[BIN_W-2:0], 1'b0};

  // Leading-zero flags from the digits produced by the final shift.
  always_comb begin
    logic all_zero;
    lz_next  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (dig_shift[4*i +: 4] == 4'd0);
      lz_next[i] = all_zero;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)              state_d = SHIFT;
      SHIFT:   if (last_shift)          state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
      out_lz  <= '0;
    end else begin
      if (accept) begin
        dig_q <= '0;
        mag_q <= mag_in;
        cnt_q <= CNT_W'(BIN_W);
        neg_q <= in_is_neg;
        ovf_q <= 1'b0;
      end else if (state_q == SHIFT) begin
        dig_q <= dig_shift;
        mag_q <= mag_shift;
        cnt_q <= cnt_q - 1'b1;
        ovf_q <= ovf_q | ovf_bit;
      end
      // Result registers load once, on the last shift, and hold through DONE.
      if (last_shift) begin
        out_bcd <= dig_shift;
        out_neg <= neg_q;
        out_ovf <= ovf_q | ovf_bit;
        out_lz  <= lz_next;
      end
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, multi-cycle binary-to-BCD converter using a sequential double-dabble datapath (one shift per clock). It accepts an unsigned or two's-complement binary word over a valid/ready handshake and returns a packed BCD result with sign, overflow and leading-zero flags over a second valid/ready handshake. It sits between datapath counters or measurement registers and display or serial formatting logic, and is sized by parameters rather than fixed at 8 bits.

## Interface
- BIN_W, 16, binary input width, 2..32
- DIGITS, 5, number of BCD output digits, 1..10; fewer digits than needed is legal and reports through out_ovf
- SIGNED, 0, 1 = in_bin is two's complement, 0 = unsigned
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_bin is valid
- in_ready  out  1  converter can accept a word
- in_bin  in  BIN_W  binary word to convert
- out_valid  out  1  result is valid and held stable
- out_ready  in  1  consumer accepts the result
- out_bcd  out  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0]
- out_neg  out  1  input was negative (SIGNED=1 only; else 0)
- out_ovf  out  1  magnitude ≥ 10^DIGITS; out_bcd holds magnitude mod 10^DIGITS
- out_lz  out  DIGITS  bit i = 1 if digit i and every higher digit are 0, for i ≥ 1; bit 0 always 0

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - Capture the magnitude: in_bin, or its two's-complement negation when SIGNED=1 and in_bin[BIN_W-1]=1. The result is a BIN_W-bit unsigned magnitude, so -2^(BIN_W-1) maps to 2^(BIN_W-1).
  - Latch neg; clear the digit registers and the ovf sticky; load the counter with BIN_W; go to SHIFT.
- SHIFT, once per cycle:
  - Every digit ≥ 5 gets +3, in parallel.
  - Shift {digits, magnitude} left by 1.
  - The bit leaving the top digit's MSB sets the ovf sticky.
  - Decrement the counter. When the counter reaches 0 after the shift, go to DONE.
- DONE:
  - out_valid=1. out_bcd, out_neg, out_ovf and out_lz are registered and stable until out_valid&out_ready.
  - On that handshake, go to IDLE the next cycle.
- in_ready=0 in SHIFT and DONE. in_bin changes there are ignored.
- out_lz is computed from the final digits at the transition to DONE.
- Width rules:
  - Per-digit +3 is 4-bit with no carry. Double dabble never produces a digit > 9 after adjust+shift.
  - The internal shift register is 4*DIGITS+BIN_W bits wide.

## Timing
- Reset (async assert, synchronous release): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_neg=0, out_ovf=0, out_lz=0, counter=0.
- Latency:
  - Input handshake at edge N.
  - out_valid rises after edge N+BIN_W (SHIFT occupies BIN_W cycles).
- Throughput: one conversion per BIN_W+2 cycles with out_ready held high. There is no overlap between input and output.
- Backpressure: out_valid stays high indefinitely while out_ready=0. No new input is accepted.
- out_ready asserted while out_valid=0 has no effect.
- Reset asserted mid-SHIFT or in DONE aborts immediately. The pending result is discarded; there is no partial output.
- Input handshake and output handshake cannot coincide, because in_ready and out_valid are mutually exclusive.

## Test plan
- BIN_W=8, DIGITS=3, SIGNED=0: in_bin=255 -> out_bcd=0x255, ovf=0, lz=000, out_valid exactly 8 cycles after accept; in_bin=0 -> 0x000, lz=110; in_bin=42 -> 0x042, lz=100.
- BIN_W=16, DIGITS=5: in_bin=65535 -> out_bcd=0x65535, ovf=0; in_bin=10000 -> 0x10000; in_bin=9 -> 0x00009, lz=11110.
- SIGNED=1, BIN_W=8, DIGITS=3: in_bin=0x80 -> neg=1, bcd=0x128; 0xFF -> neg=1, 0x001; 0x7F -> neg=0, 0x127.
- BIN_W=8, DIGITS=2: in_bin=200 -> ovf=1, bcd=0x00; in_bin=99 -> ovf=0, bcd=0x99; in_bin=100 -> ovf=1, bcd=0x00.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. Release -> one transfer, in_ready=1 the next cycle, and the next word converts correctly.
- Reset mid-SHIFT (cycle 3 of 8) -> all outputs at reset values. The next conversion of 123 -> 0x123, with no residue from the aborted word.
